// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder
//
// Assembles PS/2 Set-2 scan-code sequences from the receive-stage byte
// stream and emits one single-cycle key event per completed sequence.
// Handles the E0 extended prefix, the F0 break prefix and the 8-byte E1
// Pause sequence. Keeps level "held" flags for the maze-control keys.
// A partial sequence is dropped (seq_error pulse) when a bad byte arrives
// or when no byte follows within TIMEOUT_CYCLES.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   received_data    byte from the PS/2 receiver
//   received_data_en one-cycle strobe, received_data valid
//   key_valid        one-cycle pulse, event fields valid
//   key_code         final scan code of the event (E1 for Pause)
//   key_extended     sequence carried the E0 prefix
//   key_break        1 = release, 0 = press
//   key_held         {esc, enter, right, left, down, up} currently pressed
//   seq_error        one-cycle pulse, partial sequence dropped
//
// Build option:
//   PS2_TYPEMATIC_FILTER_EN  suppress typematic repeats of the last make
//
// State   | meaning
// --------+---------------------------------------------
// IDLE    | no sequence in progress
// EXT     | E0 seen, waiting for code or F0
// BRK     | F0 seen, waiting for code
// EXT_BRK | E0 F0 seen, waiting for code
// PAUSE   | E1 seen, skipping the trailing Pause bytes
// ---------------------------------------------------------------------------
module ps2_scancode_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TMO_W          = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_break,
    output logic [5:0] key_held,
    output logic       seq_error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXT     = 3'd1;
    localparam logic [2:0] S_BRK     = 3'd2;
    localparam logic [2:0] S_EXT_BRK = 3'd3;
    localparam logic [2:0] S_PAUSE   = 3'd4;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [2:0]       state_q, state_d;
    logic [2:0]       skip_q, skip_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic       key_valid_q, key_valid_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_ext_q, key_ext_d;
    logic       key_brk_q, key_brk_d;
    logic [5:0] held_q, held_d;
    logic       seq_err_q, seq_err_d;

    logic       is_prefix;
    logic       is_ignore;
    logic       ev_fire;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic       err;
    logic       suppress;
    logic       emit;
    logic [5:0] hit;

    always_comb begin
        is_prefix = (received_data == 8'hE0) || (received_data == 8'hF0) ||
                    (received_data == 8'hE1);
        // Receiver/keyboard status bytes (ACK, BAT ok, echo, resend, errors)
        is_ignore = (received_data == 8'hFA) || (received_data == 8'hAA) ||
                    (received_data == 8'hEE) || (received_data == 8'hFE) ||
                    (received_data == 8'h00) || (received_data == 8'hFF);
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        tmo_d   = tmo_q;
        ev_fire = 1'b0;
        ev_code = received_data;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        err     = 1'b0;

        if (received_data_en) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (received_data == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (received_data == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (received_data == 8'hE1) begin
                        state_d = S_PAUSE;
                        skip_d  = 3'd7;
                    end else if (!is_ignore) begin
                        ev_fire = 1'b1;
                    end
                end
                S_EXT: begin
                    if (received_data == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (received_data != 8'hE0) begin
                        ev_fire = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (is_prefix) begin
                        err = 1'b1;
                    end else begin
                        ev_fire = 1'b1;
                        ev_brk  = 1'b1;
                        ev_ext  = (state_q == S_EXT_BRK);
                    end
                end
                S_PAUSE: begin
                    if (skip_q == 3'd1) begin
                        ev_fire = 1'b1;
                        ev_code = 8'hE1;
                        state_d = S_IDLE;
                        skip_d  = 3'd0;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            state_d = S_IDLE;
            skip_d  = 3'd0;
            tmo_d   = '0;
            err     = 1'b1;
        end else begin
            tmo_d = tmo_q + TMO_ONE;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [7:0] rec_code_q;
    logic       rec_ext_q;
    logic       rec_vld_q;
    logic       rec_match;

    assign rec_match = rec_vld_q && (rec_code_q == ev_code) && (rec_ext_q == ev_ext);
    assign suppress  = ev_fire && !ev_brk && rec_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_code_q <= 8'h00;
            rec_ext_q  <= 1'b0;
            rec_vld_q  <= 1'b0;
        end else if (ev_fire) begin
            if (!ev_brk) begin
                if (!rec_match) begin
                    rec_code_q <= ev_code;
                    rec_ext_q  <= ev_ext;
                    rec_vld_q  <= 1'b1;
                end
            end else if (rec_match) begin
                // releasing the recorded key re-arms it for the next press
                rec_vld_q <= 1'b0;
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign emit = ev_fire && !suppress;

    always_comb begin
        hit    = 6'b0;
        hit[0] = ev_ext  && (ev_code == 8'h75);
        hit[1] = ev_ext  && (ev_code == 8'h72);
        hit[2] = ev_ext  && (ev_code == 8'h6B);
        hit[3] = ev_ext  && (ev_code == 8'h74);
        hit[4] = !ev_ext && (ev_code == 8'h5A);
        hit[5] = !ev_ext && (ev_code == 8'h76);
    end

    always_comb begin
        key_valid_d = emit;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_brk_d   = key_brk_q;
        held_d      = held_q;
        seq_err_d   = err;
        if (emit) begin
            key_code_d = ev_code;
            key_ext_d  = ev_ext;
            key_brk_d  = ev_brk;
            held_d     = ev_brk ? (held_q & ~hit) : (held_q | hit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            skip_q      <= 3'd0;
            tmo_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_brk_q   <= 1'b0;
            held_q      <= 6'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            tmo_q       <= tmo_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_brk_q   <= key_brk_d;
            held_q      <= held_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_extended = key_ext_q;
    assign key_break    = key_brk_q;
    assign key_held     = held_q;
    assign seq_error    = seq_err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_decoder
//
// Scoreboard bench: the driver feeds bytes (directed plus random) and a
// sequence-level reference model pushes the expected events, with the cycle
// they must appear in, into a queue. A monitor on the falling edge pops and
// compares whenever key_valid or seq_error is seen, and checks that the
// sticky fields and key_held hold between events.
// Build option PS2_TYPEMATIC_FILTER_EN is honoured by the model as well.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_decoder;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rd = 8'h00;
    logic       rd_en = 1'b0;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_break;
    logic [5:0] key_held;
    logic       seq_error;

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(T), .TMO_W(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .received_data    (rd),
        .received_data_en (rd_en),
        .key_valid        (key_valid),
        .key_code         (key_code),
        .key_extended     (key_extended),
        .key_break        (key_break),
        .key_held         (key_held),
        .seq_error        (seq_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        bit         err;
        logic [7:0] code;
        bit         ext;
        bit         brk;
        logic [5:0] held;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mseq[$];
    int         last_t = 0;
    logic [5:0] mheld = 6'b0;
    bit         rec_v = 1'b0;
    logic [7:0] rec_c = 8'h00;
    bit         rec_e = 1'b0;

    function automatic int held_idx(input logic [7:0] code, input bit ext);
        if (ext && code == 8'h75) return 0;
        if (ext && code == 8'h72) return 1;
        if (ext && code == 8'h6B) return 2;
        if (ext && code == 8'h74) return 3;
        if (!ext && code == 8'h5A) return 4;
        if (!ext && code == 8'h76) return 5;
        return -1;
    endfunction

    task automatic model_emit(input logic [7:0] code, input bit ext, input bit brk, input int c);
        int   idx;
        exp_t e;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (!brk && rec_v && rec_c == code && rec_e == ext) return;
        if (!brk) begin
            rec_v = 1'b1; rec_c = code; rec_e = ext;
        end else if (rec_v && rec_c == code && rec_e == ext) begin
            rec_v = 1'b0;
        end
`endif
        idx = held_idx(code, ext);
        if (idx >= 0) mheld[idx] = !brk;
        e.c = c; e.err = 1'b0; e.code = code; e.ext = ext; e.brk = brk; e.held = mheld;
        q.push_back(e);
    endtask

    task automatic model_err(input int c);
        exp_t e;
        e.c = c; e.err = 1'b1; e.code = 8'h00; e.ext = 1'b0; e.brk = 1'b0; e.held = mheld;
        q.push_back(e);
        mseq.delete();
    endtask

    task automatic model_cycle(input bit s, input logic [7:0] b, input int c);
        bit ext;
        if (!s) begin
            if (mseq.size() > 0 && (c - last_t) >= T) model_err(c);
            return;
        end
        last_t = c;
        if (mseq.size() == 0) begin
            if (b inside {8'hE0, 8'hF0, 8'hE1}) mseq.push_back(b);
            else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) model_emit(b, 1'b0, 1'b0, c);
        end else if (mseq[0] == 8'hE1) begin
            mseq.push_back(b);
            if (mseq.size() == 8) begin
                model_emit(8'hE1, 1'b0, 1'b0, c);
                mseq.delete();
            end
        end else if (mseq[$] == 8'hF0) begin
            ext = (mseq[0] == 8'hE0);
            if (b inside {8'hE0, 8'hF0, 8'hE1}) model_err(c);
            else begin
                mseq.delete();
                model_emit(b, ext, 1'b1, c);
            end
        end else begin
            if (b == 8'hF0 || b == 8'hE0) mseq.push_back(b);
            else begin
                mseq.delete();
                model_emit(b, 1'b1, 1'b0, c);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick(input bit s, input logic [7:0] b);
        @(posedge clk);
        #2;
        reset = 1'b0;
        rd_en = s;
        rd    = s ? b : 8'h00;
        model_cycle(s, b, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b);
        tick(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        rd_en = 1'b0;
        rd    = 8'h00;
        mseq.delete();
        mheld = 6'b0;
        rec_v = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        logic [7:0] arrows[4];
        logic [7:0] ign[6];
        arrows = '{8'h75, 8'h72, 8'h6B, 8'h74};
        ign    = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        r = $urandom_range(0, 99);
        if (r < 15) return 8'hE0;
        if (r < 27) return 8'hF0;
        if (r < 30) return 8'hE1;
        if (r < 45) return arrows[$urandom_range(0, 3)];
        if (r < 55) return ($urandom_range(0, 1) != 0) ? 8'h5A : 8'h76;
        if (r < 62) return ign[$urandom_range(0, 5)];
        return 8'($urandom_range(0, 255));
    endfunction

    // ---------------- monitor ----------------
    bit         prev_rst = 1'b1;
    logic [7:0] cur_code = 8'h00;
    bit         cur_ext = 1'b0;
    bit         cur_brk = 1'b0;
    logic [5:0] cur_held = 6'b0;

    always @(negedge clk) begin
        exp_t e;
        if (prev_rst) begin
            chk("reset_outputs", {key_valid, key_code, key_extended, key_break, key_held, seq_error}, 32'h0);
            cur_code = 8'h00; cur_ext = 1'b0; cur_brk = 1'b0; cur_held = 6'b0;
        end else begin
            while (q.size() > 0 && q[0].c < cyc) begin
                e = q.pop_front();
                nchk++; nerr++;
                $display("FAIL missing_%s at cycle %0d: got none expected code %0h", e.err ? "seq_error" : "key_valid", e.c, e.code);
                cur_held = e.held;
                if (!e.err) begin cur_code = e.code; cur_ext = e.ext; cur_brk = e.brk; end
            end
            if (key_valid || seq_error) begin
                chk("valid_and_error_exclusive", {key_valid, seq_error}, key_valid ? 32'h2 : 32'h1);
                if (q.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_output at cycle %0d: got valid=%0b err=%0b code=%0h expected none", cyc, key_valid, seq_error, key_code);
                end else begin
                    e = q.pop_front();
                    chk("event_cycle", cyc, e.c);
                    chk("event_kind", seq_error, e.err);
                    cur_held = e.held;
                    if (!e.err) begin cur_code = e.code; cur_ext = e.ext; cur_brk = e.brk; end
                end
            end
            chk("key_code", key_code, cur_code);
            chk("key_extended", key_extended, cur_ext);
            chk("key_break", key_break, cur_brk);
            chk("key_held", key_held, cur_held);
        end
        prev_rst = reset;
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int g;
        repeat (2) @(posedge clk);

        // plain make / break, no held bit
        send(8'h1C);
        send(8'hF0); send(8'h1C);
        // up arrow make/break, keypad 8 does not touch up
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h75);
        send(8'hF0); send(8'h75);
        // pause sequence
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        // timeout, then strobe exactly on the expiry cycle
        tick(1'b1, 8'hE0); idle(20); send(8'h29);
        tick(1'b1, 8'hE0); idle(T - 1); send(8'h29);
        tick(1'b1, 8'hE0); idle(T);     send(8'h29);
        // reset mid-sequence, status byte ignored
        send(8'hF0); do_reset(); send(8'h1C);
        send(8'hAA);
        // typematic repeats, back-to-back strobes
        tick(1'b1, 8'h5A); tick(1'b1, 8'h5A); tick(1'b1, 8'h5A);
        tick(1'b1, 8'hF0); tick(1'b1, 8'h5A); tick(1'b1, 8'h5A);
        idle(3);
        // bad byte after break prefix
        send(8'hE0); send(8'hF0); send(8'hE1);
        send(8'hF0); send(8'hF0);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      g = 0;
            else if (r < 85) g = $urandom_range(1, 3);
            else if (r < 98) g = $urandom_range(T - 2, T + 1);
            else             g = -1;
            if (g < 0) do_reset();
            else begin
                tick(1'b1, rand_byte());
                idle(g);
            end
        end

        idle(T + 10);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
